// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART tx line among byte producers
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DIV_W   = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       en,
  input  logic [DIV_W-1:0]           baud_div,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic                       tx_busy,
  output logic                       txd
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  baud_div_q;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [ID_W-1:0]   rr_ptr;

  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   idx_v;
  logic              bit_end;
  logic              grant_now;
  logic [ID_W-1:0]   rr_next;

  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx_v   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_vld && req[idx_v]) begin
        win_vld = 1'b1;
        win_id  = idx_v;
      end
    end
  end

  assign bit_end   = (cnt == baud_div_q);
  // Arbitration points: any IDLE cycle, or the final clock of the stop bit.
  assign grant_now = en && win_vld && ((state == IDLE) || ((state == STOP) && bit_end));
  assign rr_next   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
  assign tx_busy   = (state != IDLE);

  // Frame sequencer; a grant overrides the STOP->IDLE transition for gapless back-to-back frames.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      cnt        <= '0;
      baud_div_q <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rr_ptr     <= '0;
      cur_id     <= '0;
      gnt        <= '0;
      done       <= '0;
      txd        <= 1'b1;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            cnt     <= '0;
            bit_cnt <= '0;
            txd     <= shift[0];
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            done  <= ONE << cur_id;
            state <= IDLE;
            cnt   <= '0;
            txd   <= 1'b1;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
      if (grant_now) begin
        state      <= START;
        txd        <= 1'b0;
        cnt        <= '0;
        bit_cnt    <= '0;
        shift      <= req_data[{win_id, 3'b000} +: 8];
        baud_div_q <= baud_div;
        cur_id     <= win_id;
        rr_ptr     <= rr_next;
        gnt        <= ONE << win_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] baud_div = '0;
  logic [N-1:0]  req = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [1:0]    cur_id;
  logic          tx_busy;
  logic          txd;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler #(.NUM_REQ(N), .DIV_W(DW)) dut (
    .PCLK(clk), .PRESETn(rst_n), .en(en), .baud_div(baud_div),
    .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .cur_id(cur_id), .tx_busy(tx_busy), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    en    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    rst_n = 1'b1;
  endtask

  // Reference model: frame described by elapsed clocks since the start-bit edge.
  int         m_busy, m_el, m_div, m_id, m_rr;
  logic [7:0] m_byte;
  logic [N-1:0] m_gnt, m_done;

  function automatic logic m_txd();
    int b;
    if (m_busy == 0) return 1'b1;
    b = m_el / (m_div + 1);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic m_step();
    m_gnt  = '0;
    m_done = '0;
    if (m_busy != 0) begin
      m_el++;
      if (m_el == 10 * (m_div + 1)) begin
        m_done = N'(1) << m_id;
        m_busy = 0;
      end
    end
    if (m_busy == 0 && en && req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_rr + k) % N]) begin
          m_id = (m_rr + k) % N;
          break;
        end
      end
      m_rr   = (m_id + 1) % N;
      m_busy = 1;
      m_el   = 0;
      m_div  = int'(baud_div);
      m_byte = req_data[m_id*8 +: 8];
      m_gnt  = N'(1) << m_id;
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] data;
    int         div;
    logic [9:0] frame;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int g;
    int order[5];
    logic [31:0] d1;
    vecs[0] = '{id: 2, data: 8'hA5, div: 3, frame: 10'b1101001010, exp_gnt: 4'b0100};
    vecs[1] = '{id: 0, data: 8'hFF, div: 0, frame: 10'b1111111110, exp_gnt: 4'b0001};
    vecs[2] = '{id: 3, data: 8'h00, div: 1, frame: 10'b1000000000, exp_gnt: 4'b1000};
    vecs[3] = '{id: 1, data: 8'h3C, div: 2, frame: 10'b1001111000, exp_gnt: 4'b0010};

    // Single-frame vectors; baud_div is changed right after grant and must not matter.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      en       = 1'b1;
      baud_div = DW'(vecs[v].div);
      req_data[vecs[v].id*8 +: 8] = vecs[v].data;
      req      = N'(1) << vecs[v].id;
      for (int c = 1; c <= 10 * (vecs[v].div + 1) + 1; c++) begin
        @(negedge clk);
        if (c == 1) begin
          chk("vec_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
          chk("vec_cur_id", 32'(cur_id), 32'(vecs[v].id));
          req      = '0;
          baud_div = DW'(7);
        end
        if (c == 2) chk("vec_gnt_pulse", 32'(gnt), 32'd0);
        if (c <= 10 * (vecs[v].div + 1)) begin
          chk("vec_txd", 32'(txd), 32'(vecs[v].frame[(c-1) / (vecs[v].div + 1)]));
          chk("vec_busy", 32'(tx_busy), 32'd1);
          chk("vec_no_done", 32'(done), 32'd0);
        end else begin
          chk("vec_done", 32'(done), 32'(vecs[v].exp_gnt));
          chk("vec_idle_busy", 32'(tx_busy), 32'd0);
          chk("vec_idle_txd", 32'(txd), 32'd1);
        end
      end
      @(negedge clk);
      chk("vec_done_pulse", 32'(done), 32'd0);
    end

    // Contention: all four requesting continuously.
    do_reset();
    order    = '{0, 1, 2, 3, 0};
    en       = 1'b1;
    baud_div = '0;
    req_data = 32'h44332211;
    req      = 4'b1111;
    g = 0;
    for (int cyc = 0; cyc < 200 && g < 5; cyc++) begin
      @(negedge clk);
      if (gnt != '0) begin
        chk("cont_gnt", 32'(gnt), 32'(N'(1) << order[g]));
        if (g > 0) chk("cont_done_with_gnt", 32'(done), 32'(N'(1) << order[g-1]));
        g++;
      end
      if (g > 0) chk("cont_no_gap", 32'(tx_busy), 32'd1);
    end
    chk("cont_grant_count", 32'(g), 32'd5);

    // Asynchronous reset mid-DATA after rr_ptr has moved past requester 2.
    do_reset();
    en       = 1'b1;
    baud_div = DW'(2);
    req_data = 32'h11223344;
    req      = 4'b0100;
    @(negedge clk);
    req = '0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 32'(tx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 32'(txd), 32'd1);
    chk("async_rst_busy", 32'(tx_busy), 32'd0);
    chk("async_rst_cur_id", 32'(cur_id), 32'd0);
    d1 = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rst_n = 1'b1;
        req   = 4'b1010;
      end
      if (c == 2) chk("post_rst_gnt", 32'(gnt), 32'b0010);
      if (c == 2) req = '0;
      if (done != '0) d1 = 32'(done);
    end
    chk("post_rst_done_new_frame_only", d1, 32'b0010);

    // Randomized run against the reference model.
    do_reset();
    en = 1'b1;
    baud_div = DW'(1);
    m_busy = 0; m_el = 0; m_div = 0; m_id = 0; m_rr = 0; m_byte = '0;
    m_gnt = '0; m_done = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      chk("rnd_txd", 32'(txd), 32'(m_txd()));
      chk("rnd_busy", 32'(tx_busy), 32'(m_busy != 0));
      chk("rnd_gnt", 32'(gnt), 32'(m_gnt));
      chk("rnd_done", 32'(done), 32'(m_done));
      if (m_busy != 0) chk("rnd_cur_id", 32'(cur_id), 32'(m_id));
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else req_data[i*8 +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(7, 0) == 0) begin
          req_data[i*8 +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(63, 0) == 0) en = ~en;
      if ($urandom_range(15, 0) == 0) baud_div = DW'($urandom_range(3, 0));
      m_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin transmit scheduler that shares one UART serial line between several byte producers. It arbitrates among requesters, latches the granted byte, and sequences the frame: start bit, 8 data bits LSB first, stop bit. Bit timing comes from an internal divider. It sits between the APB-side register logic and the `txd` pin and replaces direct `tx_en` and `tx_data` driving of the transmitter.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DIV_W`, default 16: width of the bit-period divider.
- `PCLK` in 1: single clock; all logic is on its rising edge.
- `PRESETn` in 1: asynchronous, active-low reset.
- `en` in 1: scheduler enable. When low, no new grants are issued and a frame in flight completes.
- `baud_div` in `DIV_W`: clocks per bit minus 1. Sampled only at frame start.
- `req` in `NUM_REQ`: level request, one bit per requester.
- `req_data` in `NUM_REQ*8`: byte of requester i is at `[8i+7:8i]`.
- `gnt` out `NUM_REQ`: one-cycle pulse, one-hot. The byte of that requester has been consumed.
- `done` out `NUM_REQ`: one-cycle pulse, one-hot. The stop bit of that requester's frame has completed.
- `cur_id` out `$clog2(NUM_REQ)`: index of the requester whose frame is on the line. Valid while `tx_busy` is high.
- `tx_busy` out 1: high in every state except IDLE.
- `txd` out 1: serial output, registered.

## Operation
- States:
  - IDLE: `txd`=1.
  - START: `txd`=0.
  - DATA: `txd`=`shift[0]`.
  - STOP: `txd`=1.
- Each bit lasts exactly `baud_div_q+1` clocks, where `baud_div_q` is the value latched at grant. `baud_div`=0 gives 1 clock per bit.
- A bit counter (0..7) counts the DATA bits. The shift register shifts right at each DATA bit boundary.
- Arbitration runs in two places:
  - In IDLE, when `en`=1 and `req`≠0.
  - In the last cycle of STOP, when `en`=1 and `req`≠0.
- The winner is the first set `req` bit searching upward from `rr_ptr` with wrap. After each grant, `rr_ptr` is set to winner+1 mod `NUM_REQ`. Reset value of `rr_ptr` is 0.
- On a grant edge:
  - `shift` ← winner's byte.
  - `baud_div_q` ← `baud_div`.
  - `cur_id` ← winner.
  - State → START, `txd` ← 0.
  - `gnt[winner]` is high in the following cycle.
- End of STOP:
  - `done[cur_id]` pulses in the cycle after the final STOP clock.
  - If an arbitration win occurred at that edge, the state goes straight to START with no idle gap, and `gnt` for the new winner pulses in the same cycle as `done`.
  - Otherwise the state goes to IDLE.
- Requester rule: keep `req` and data stable until `gnt` is seen. In the `gnt` cycle, either present the next byte or drop `req`. The scheduler ignores `req` outside arbitration points, so this is always safe.
- `en` falling mid-frame: the frame finishes normally and `done` still pulses, then the state goes to IDLE.
- `req` bits that rise or fall between arbitration points have no effect.
- `baud_div` changes mid-frame have no effect until the next grant.
- Reset asserted at any time, including mid-frame:
  - Immediately `txd`=1, `tx_busy`=0, `gnt`=0, `done`=0, `cur_id`=0, state IDLE, `rr_ptr`=0.
  - The aborted frame produces no `done`.

## Timing
- Reset values: `txd`=1, `tx_busy`=0, `gnt`=0, `done`=0, `cur_id`=0.
- From IDLE:
  - `req` high at edge T → `txd`=0 and `tx_busy`=1 from T.
  - `gnt` pulses in cycle T..T+1.
- Frame length is `10*(baud_div+1)` clocks from the start-bit edge to the end of the stop bit.
- Back-to-back frames have no gap: the next start bit begins on the clock after the final stop clock.
- From IDLE, at least one IDLE clock is observed after `en` or `req` goes low.
- `gnt` is asserted at most once per frame. `gnt` and `done` are never asserted for more than one cycle.

## Test plan
- Single byte, `NUM_REQ`=4, `baud_div`=3, `req[2]`=1 with 0xA5 → `gnt`=4'b0100 for 1 cycle; `txd` shows 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; `done`=4'b0100 40 clocks after start; `cur_id`=2.
- Contention: `req`=4'b1111 held continuously, with each requester presenting a new byte on `gnt` → grant order 0,1,2,3,0; no idle cycle between frames; each `done` pulse coincides with the next `gnt` pulse.
- Round-robin fairness: `req`=4'b1001 continuously → grants alternate 0,3,0,3; `rr_ptr` wraps from 3 to 0.
- `baud_div`=0 with byte 0xFF → 10-clock frame: one 0 bit then nine 1 bits. Changing `baud_div` to 7 mid-frame does not alter that frame; the next frame uses 8 clocks per bit.
- `en` dropped during DATA with `req[1]` pending → current frame completes, `done` pulses, state goes to IDLE, no `gnt[1]` until `en`=1 again.
- `PRESETn` pulsed low mid-DATA → `txd`=1 and `tx_busy`=0 asynchronously with no clock edge; no `done`; after release, the first grant goes to the lowest set `req` bit (`rr_ptr`=0).
